// File: rtl/la_tx_buffer_if.sv
// -----------------------------------------------------------------------------
// la_tx_buffer_if
// Purpose : Groups the packet-in strobe and the host-side valid/ready bus of
//           la_tx_buffer into one bundle.
// Signals : packet_in        payload from the logic-analyzer top
//           packet_in_valid  single-cycle strobe qualifying packet_in
//           packet_out       {PERIPH_ADDR, FIFO head} towards the arbiter
//           out_valid        packet_out holds a valid packet
//           out_ready        arbiter accepts when out_valid && out_ready
// Modports: slave  - the buffer itself (consumes payload, drives packet_out)
//           master - the environment (drives payload and out_ready)
// -----------------------------------------------------------------------------
interface la_tx_buffer_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 3
);
  logic [WIDTH-ADDR_WIDTH-1:0] packet_in;
  logic                        packet_in_valid;
  logic [WIDTH-1:0]            packet_out;
  logic                        out_valid;
  logic                        out_ready;

  modport slave (
    input  packet_in,
    input  packet_in_valid,
    input  out_ready,
    output packet_out,
    output out_valid
  );

  modport master (
    output packet_in,
    output packet_in_valid,
    output out_ready,
    input  packet_out,
    input  out_valid
  );
endinterface

// File: rtl/la_tx_buffer.sv
// -----------------------------------------------------------------------------
// la_tx_buffer
// Purpose : First-word-fall-through buffer between the logic-analyzer payload
//           source and the shared host-TX arbiter. Each stored payload is
//           presented as {PERIPH_ADDR, payload}. Packets arriving while the
//           FIFO is full (and nothing is popped) are discarded and counted in
//           a saturating drop counter.
// Ports   : clk          system clock
//           rst          synchronous, active-high reset
//           bus          la_tx_buffer_if.slave (packet_in, packet_in_valid,
//                        packet_out, out_valid, out_ready)
//           fifo_level   registered occupancy, 0..DEPTH
//           drop_count   saturating count of discarded packets
//           clear_drops  synchronous clear of drop_count
// Options : `define LA_TX_OVF_PKT_EN to enqueue an internal status packet
//           {1, 2'b10, 2'b00, 8'hEE, drop_count[15:0]} after any drop, as soon
//           as there is room and no incoming data competes for the slot.
// -----------------------------------------------------------------------------
module la_tx_buffer #(
  parameter int                  WIDTH       = 32,
  parameter int                  ADDR_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_ADDR = 3'd0,
  parameter int                  DEPTH       = 8,
  parameter int                  DROP_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  la_tx_buffer_if.slave              bus,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [DROP_W-1:0]          drop_count,
  input  logic                       clear_drops
);

  localparam int PW = WIDTH - ADDR_WIDTH;  // payload width
  localparam int AW = $clog2(DEPTH);       // pointer width
  localparam int LW = AW + 1;              // level width (holds DEPTH)

  // Elaboration-time sanity check on the FIFO geometry.
  generate
    if ((DEPTH < 2) || (DEPTH > 64) || ((1 << AW) != DEPTH)) begin : g_bad_depth
      $error("la_tx_buffer: DEPTH must be a power of two in 2..64");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_pkt_out;
  logic [DROP_W-1:0] r_drop;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  logic              w_full;
  logic              w_pop;
  logic              w_in_accept;
  logic              w_drop;
  logic              w_ins;
  logic              w_push;
  logic [PW-1:0]     w_push_data;
  logic [AW-1:0]     w_wr_next;
  logic [AW-1:0]     w_rd_next;
  logic [LW-1:0]     w_level_next;
  logic [DROP_W-1:0] w_drop_next;
  logic [PW-1:0]     w_head_next;
  logic [WIDTH-1:0]  w_pkt_next;

  assign w_full = (r_level == LW'(DEPTH));

  // out_valid is a register, so out_ready only reaches the push/pop decision,
  // never out_valid itself within the same cycle.
  assign w_pop = r_out_valid & bus.out_ready;

  // A push while full is still accepted when the same cycle pops the head.
  assign w_in_accept = bus.packet_in_valid & (~w_full | w_pop);
  assign w_drop      = bus.packet_in_valid & w_full & ~w_pop;

`ifdef LA_TX_OVF_PKT_EN
  logic          r_pending;
  logic [15:0]   w_drop16;
  logic [PW-1:0] w_status;

  assign w_drop16 = 16'(w_drop_next);

  // Status payload reports the drop count as it stands after this edge.
  assign w_status = {1'b1, 2'b10, 2'b00, 8'hEE, w_drop16};

  // Insertion only uses a genuinely free slot and yields to incoming data.
  assign w_ins = r_pending & ~w_full & ~bus.packet_in_valid;

  // Status-pending flag: set by any drop, cleared once the status is queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_drop) begin
      r_pending <= 1'b1;
    end else if (w_ins) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= r_pending;
    end
  end
`else
  assign w_ins = 1'b0;
`endif

  assign w_push = w_in_accept | w_ins;

  // Select what is written into the FIFO this cycle.
  always_comb begin
    w_push_data = bus.packet_in;
`ifdef LA_TX_OVF_PKT_EN
    if (w_ins) begin
      w_push_data = w_status;
    end else begin
      w_push_data = bus.packet_in;
    end
`endif
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    w_wr_next    = r_wr_ptr;
    w_rd_next    = r_rd_ptr;
    w_level_next = r_level;
    if (w_push) begin
      w_wr_next = r_wr_ptr + AW'(1);
    end else begin
      w_wr_next = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_next = r_rd_ptr + AW'(1);
    end else begin
      w_rd_next = r_rd_ptr;
    end
    if (w_push && !w_pop) begin
      w_level_next = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_next = r_level - LW'(1);
    end else begin
      w_level_next = r_level;
    end
  end

  // Saturating drop counter; a clear that coincides with a drop leaves 1.
  always_comb begin
    w_drop_next = r_drop;
    if (clear_drops) begin
      if (w_drop) begin
        w_drop_next = DROP_W'(1);
      end else begin
        w_drop_next = {DROP_W{1'b0}};
      end
    end else if (w_drop && !(&r_drop)) begin
      w_drop_next = r_drop + DROP_W'(1);
    end else begin
      w_drop_next = r_drop;
    end
  end

  // Next head of the FIFO. The slot at the new read pointer is being written
  // this cycle only when the FIFO is (or becomes) empty, so forward the
  // incoming word in that case to get the one-cycle fall-through.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_push && (w_rd_next == r_wr_ptr)) begin
      w_head_next = w_push_data;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
    if (w_level_next != LW'(0)) begin
      w_pkt_next = {PERIPH_ADDR, w_head_next};
    end else begin
      w_pkt_next = {WIDTH{1'b0}};
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // Pointers, level, registered outputs and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_level     <= {LW{1'b0}};
      r_out_valid <= 1'b0;
      r_pkt_out   <= {WIDTH{1'b0}};
      r_drop      <= {DROP_W{1'b0}};
    end else begin
      r_wr_ptr    <= w_wr_next;
      r_rd_ptr    <= w_rd_next;
      r_level     <= w_level_next;
      r_out_valid <= (w_level_next != LW'(0));
      r_pkt_out   <= w_pkt_next;
      r_drop      <= w_drop_next;
    end
  end

  assign bus.packet_out = r_pkt_out;
  assign bus.out_valid  = r_out_valid;
  assign fifo_level     = r_level;
  assign drop_count     = r_drop;

endmodule
